tc_mul_arbiter: RTL and testbench

Round-robin arbiter and pipeline sequencer that shares one 16-bit-unsigned × 18-bit-signed → 31-bit-signed DSP multiplier among NREQ requesters inside a TrackletCalculator instance. It is used for the low-rate rinv/phi0/z0 products, which do not justify one DSP each. It accepts operand pairs over valid/ready, issues at most one per cycle into an LAT-stage multiplier pipeline, and returns each product tagged with the originating requester index. The whole pipeline stalls under output backpressure.

---
 rtl/tc_mul_arbiter.sv | 139 +++++++++++++
 tb/tb_tc_mul_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tc_mul_arbiter.sv
// Round-robin share of one 16u x 18s -> 31s multiplier among NREQ requesters; results tagged with requester id.
// Latency: LAT cycles from grant to res_valid, plus one cycle per stall cycle; one issue per cycle.
// Backpressure: res_valid && !res_ready freezes every stage and forces req_ready to zero.
// Option TC_MUL_ARB_STRICT_PRIO_EN: requester 0 gets strict priority, the rest round-robin.
module tc_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [18*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [30:0]          res_p,
    input  logic                 res_ready,
    output logic                 idle
);

`ifdef TC_MUL_ARB_STRICT_PRIO_EN
    localparam int RR_LO = 1;
`else
    localparam int RR_LO = 0;
`endif
    localparam int RR_N = NREQ - RR_LO;
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW:0]   RR_N_W  = (IDW+1)'(RR_N);
    localparam logic [IDW-1:0] RR_LO_P = IDW'(RR_LO);

    logic [LAT-1:0] stg_vld;
    logic [IDW-1:0] stg_id [LAT];
    logic [15:0]    stg_a  [LAT];
    logic [17:0]    stg_b  [LAT];

    logic [IDW-1:0] rr_ptr;
    logic           advance;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [IDW:0]   scan;
    logic [IDW:0]   ptr_sum;
    logic [IDW-1:0] ptr_nxt;
    logic [15:0]    a_sel;
    logic [17:0]    b_sel;

    assign res_valid = stg_vld[LAT-1];
    assign advance   = !res_valid || res_ready;

    // Scan RR_N requesters starting at rr_ptr; the window wraps back to RR_LO.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        scan    = '0;
        if (!ap_rst && advance) begin
`ifdef TC_MUL_ARB_STRICT_PRIO_EN
            if (req_valid[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = '0;
            end
`endif
            for (int k = 0; k < RR_N; k++) begin
                scan = {1'b0, rr_ptr} + (IDW+1)'(k);
                if (scan >= NREQ_W)
                    scan = scan - RR_N_W;
                if (!gnt_vld && req_valid[scan[IDW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = scan[IDW-1:0];
                end
            end
            if (gnt_vld)
                gnt[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt;

    always_comb begin
        ptr_sum = {1'b0, gnt_idx} + (IDW+1)'(1);
        ptr_nxt = (ptr_sum >= NREQ_W) ? RR_LO_P : ptr_sum[IDW-1:0];
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[16*i +: 16];
                b_sel = req_b[18*i +: 18];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stg_vld <= '0;
            rr_ptr  <= RR_LO_P;
            for (int s = 0; s < LAT; s++) begin
                stg_id[s] <= '0;
                stg_a[s]  <= '0;
                stg_b[s]  <= '0;
            end
        end else if (advance) begin
            stg_vld[0] <= gnt_vld;
            stg_id[0]  <= gnt_idx;
            stg_a[0]   <= a_sel;
            stg_b[0]   <= b_sel;
            for (int s = 1; s < LAT; s++) begin
                stg_vld[s] <= stg_vld[s-1];
                stg_id[s]  <= stg_id[s-1];
                stg_a[s]   <= stg_a[s-1];
                stg_b[s]   <= stg_b[s-1];
            end
            if (gnt_vld) begin
`ifdef TC_MUL_ARB_STRICT_PRIO_EN
                // Priority grants to requester 0 leave the round-robin position untouched.
                if (gnt_idx != '0)
                    rr_ptr <= ptr_nxt;
`else
                rr_ptr <= ptr_nxt;
`endif
            end
        end
    end

    // Only the low 31 product bits are kept, so operands are extended to 31 bits and wrap naturally.
    logic signed [30:0] a_ext;
    logic signed [30:0] b_ext;
    assign a_ext = {15'b0, stg_a[LAT-1]};
    assign b_ext = {{13{stg_b[LAT-1][17]}}, stg_b[LAT-1]};

    assign res_id = stg_id[LAT-1];
    assign res_p  = a_ext * b_ext;
    assign idle   = (stg_vld == '0) && (req_valid == '0);

endmodule

// File: tb/tb_tc_mul_arbiter.sv
// Directed bench for tc_mul_arbiter (NREQ=4, LAT=2): reset, single op, fairness, backpressure, wrap, reset mid-flight.
module tb_tc_mul_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic [NREQ-1:0]     req_valid;
    logic [16*NREQ-1:0]  req_a;
    logic [18*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [30:0]         res_p;
    logic                res_ready;
    logic                idle;

    int nerr = 0;
    int nchk = 0;

    int bp_rr [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int bp_rv [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int bp_g  [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int bp_o  [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};

    always #5 ap_clk = ~ap_clk;

    tc_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .res_ready (res_ready),
        .idle      (idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [17:0] b);
        req_a[16*i +: 16] = a;
        req_b[18*i +: 18] = b;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
    endtask

    initial begin
        int nxt;
        int id;
        ap_rst    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset: no grants while held, clean outputs afterwards.
        step();
        req_valid = 4'hF;
        #1 chk("rst_ready", req_ready, 0);
        req_valid = '0;
        step();
        ap_rst = 1'b0;
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_id", res_id, 0);
        chk("rst_p", res_p, 0);
        chk("rst_idle", idle, 1);

        // Single op: 0xFFFF * -1 = -65535 -> 0x7FFF0001 in 31 bits.
        set_op(2, 16'hFFFF, 18'h3FFFF);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        chk("single_busy", idle, 0);
        step();
        req_valid = '0;
        #1 chk("single_lat1", res_valid, 0);
        step();
        chk("single_valid", res_valid, 1);
        chk("single_id", res_id, 2);
        chk("single_p", res_p, 31'h7FFF0001);
        step();
        chk("single_done", res_valid, 0);
        chk("single_idle", idle, 1);

`ifndef TC_MUL_ARB_STRICT_PRIO_EN
        // Fairness: all requesters valid, grants rotate 0..3.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_op(i, 16'(i + 1), 18'(i + 5));
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_ready", req_ready, 64'(1 << (c % 4)));
            if (c >= 2) begin
                id = (c - 2) % 4;
                chk("fair_valid", res_valid, 1);
                chk("fair_id", res_id, 64'(id));
                chk("fair_p", res_p, 64'((id + 1) * (id + 5)));
            end
            step();
        end
        req_valid = '0;
        step();
        step();
        #1 chk("fair_idle", idle, 1);
`endif

        // Backpressure: stream from requester 1, stall three cycles.
        do_reset();
        nxt = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (bp_rv[c] != 0) ? 4'b0010 : 4'b0000;
            res_ready = bp_rr[c][0];
            set_op(1, 16'(100 + nxt), 18'd3);
            #1;
            chk("bp_ready", req_ready, (bp_g[c] != 0) ? 4'b0010 : 4'b0000);
            if (bp_o[c] >= 0) begin
                chk("bp_valid", res_valid, 1);
                chk("bp_id", res_id, 1);
                chk("bp_p", res_p, 64'(3 * (100 + bp_o[c])));
            end else begin
                chk("bp_novalid", res_valid, 0);
            end
            if (bp_g[c] != 0)
                nxt++;
            step();
        end
        res_ready = 1'b1;
        req_valid = '0;

        // Wrap: 0xFFFF * 0x1FFFF = 0x1FFFD0001, low 31 bits 0x7FFD0001.
        set_op(0, 16'hFFFF, 18'h1FFFF);
        req_valid = 4'b0001;
        #1 chk("wrap_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        chk("wrap_valid", res_valid, 1);
        chk("wrap_p", res_p, 31'h7FFD0001);
        step();

`ifndef TC_MUL_ARB_STRICT_PRIO_EN
        // Reset mid-flight: in-flight op from requester 3 must vanish.
        set_op(3, 16'd7, 18'd9);
        set_op(0, 16'd5, 18'd6);
        req_valid = 4'b1001;
        #1 chk("mf_ready0", req_ready, 4'b1000);
        step();
        ap_rst = 1'b1;
        #1 chk("mf_rst_ready", req_ready, 0);
        step();
        ap_rst = 1'b0;
        #1;
        chk("mf_novalid0", res_valid, 0);
        chk("mf_ready_low", req_ready, 4'b0001);
        step();
        req_valid = '0;
        #1 chk("mf_novalid1", res_valid, 0);
        step();
        chk("mf_valid", res_valid, 1);
        chk("mf_id", res_id, 0);
        chk("mf_p", res_p, 30);
        step();
`else
        // Strict priority: requester 0 wins while valid, then 2 gets served.
        do_reset();
        set_op(0, 16'd2, 18'd3);
        set_op(2, 16'd4, 18'd5);
        req_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1 chk("sp_ready0", req_ready, 4'b0001);
            step();
        end
        req_valid = 4'b0100;
        #1 chk("sp_ready2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (3) step();
`endif
        chk("end_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
